pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_perf_cnt.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencing FSM states, control bundle encodings,
// and the load-use hazard detector.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_REDIRECT = 2'd3
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic redirect;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(8'b0000_0000);
  localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(8'b1111_1000);
  // Load-use bubble: hold PC and IF/ID, push a bubble into ID/EX, drain EX onward.
  localparam hz_ctrl_t CTRL_LU     = hz_ctrl_t'(8'b0011_1010);
  localparam hz_ctrl_t CTRL_MP     = hz_ctrl_t'(8'b1111_1111);

  function automatic logic load_use(
    input logic [4:0] rs1_id,
    input logic [4:0] rs2_id,
    input logic       rs1_used_id,
    input logic       rs2_used_id,
    input logic [4:0] rd_ex,
    input logic       wb_reg_file_ex,
    input logic       memtoreg_ex
  );
    return memtoreg_ex && wb_reg_file_ex && (rd_ex != 5'd0) &&
           ((rs1_used_id && (rd_ex == rs1_id)) ||
            (rs2_used_id && (rd_ex == rs2_id)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID / ID-EX and pipeline-register controls plus perf counters.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic [4:0]       rd_ex;
  logic             wb_reg_file_ex;
  logic             memtoreg_ex;
  logic             mispredict_ex;
  logic             dmem_busy;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             redirect;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [1:0]       state_o;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           wb_reg_file_ex, memtoreg_ex, mispredict_ex, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, redirect,
           stall_cycles, flush_events, state_o
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           wb_reg_file_ex, memtoreg_ex, mispredict_ex, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, redirect,
           stall_cycles, flush_events, state_o
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, mispredict redirects and
// dmem freezes, with saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  hz_state_e  r_state;
  hz_state_e  r_ret;
  logic [1:0] r_bcnt;
  logic       r_redir_pend;

  hz_state_e  w_state_nxt;
  hz_state_e  w_ret_nxt;
  logic [1:0] w_bcnt_nxt;
  logic       w_redir_pend_nxt;
  hz_ctrl_t   w_ctrl_fsm;
  hz_ctrl_t   w_ctrl;
  logic       w_lu;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_lu = load_use(bus.rs1_id, bus.rs2_id, bus.rs1_used_id, bus.rs2_used_id,
                         bus.rd_ex, bus.wb_reg_file_ex, bus.memtoreg_ex);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_ret        <= ST_RUN;
      r_bcnt       <= '0;
      r_redir_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_redir_pend <= w_redir_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ret_nxt        = r_ret;
    w_bcnt_nxt       = r_bcnt;
    w_redir_pend_nxt = r_redir_pend;
    w_ctrl_fsm       = CTRL_FREEZE;

    unique case (r_state)
      ST_RUN: begin
        if (bus.dmem_busy) begin
          w_ctrl_fsm  = CTRL_FREEZE;
          w_ret_nxt   = ST_RUN;
          w_state_nxt = ST_MEM_WAIT;
          if (bus.mispredict_ex) w_redir_pend_nxt = 1'b1;
        end else if (bus.mispredict_ex) begin
          w_ctrl_fsm = CTRL_MP;
        end else if (w_lu) begin
          w_ctrl_fsm = CTRL_LU;
          if (LOAD_BUBBLES > 1) begin
            w_bcnt_nxt  = 2'(LOAD_BUBBLES - 1);
            w_state_nxt = ST_LD_STALL;
          end
        end else begin
          w_ctrl_fsm = CTRL_RUN;
        end
      end

      ST_LD_STALL: begin
        if (bus.dmem_busy) begin
          // Freeze keeps r_bcnt so the remaining bubbles resume afterwards.
          w_ctrl_fsm  = CTRL_FREEZE;
          w_ret_nxt   = ST_LD_STALL;
          w_state_nxt = ST_MEM_WAIT;
          if (bus.mispredict_ex) w_redir_pend_nxt = 1'b1;
        end else if (bus.mispredict_ex) begin
          w_ctrl_fsm  = CTRL_MP;
          w_bcnt_nxt  = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_ctrl_fsm = CTRL_LU;
          w_bcnt_nxt = r_bcnt - 2'd1;
          if (r_bcnt <= 2'd1) w_state_nxt = ST_RUN;
        end
      end

      ST_MEM_WAIT: begin
        w_ctrl_fsm = CTRL_FREEZE;
        if (bus.mispredict_ex) w_redir_pend_nxt = 1'b1;
        if (!bus.dmem_busy) begin
          w_state_nxt = (r_redir_pend || bus.mispredict_ex) ? ST_REDIRECT : r_ret;
        end
      end

      ST_REDIRECT: begin
        w_ctrl_fsm       = CTRL_MP;
        w_redir_pend_nxt = 1'b0;
        w_state_nxt      = ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Reset forces every control low, independent of the registered state.
  assign w_ctrl = rst_n ? w_ctrl_fsm : CTRL_FREEZE;

  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (~w_ctrl.pc_en),
    .o_count (w_stall_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_ctrl.redirect),
    .o_count (w_flush_cnt)
  );

  assign bus.pc_en        = w_ctrl.pc_en;
  assign bus.if_id_en     = w_ctrl.if_id_en;
  assign bus.id_ex_en     = w_ctrl.id_ex_en;
  assign bus.ex_mem_en    = w_ctrl.ex_mem_en;
  assign bus.mem_wb_en    = w_ctrl.mem_wb_en;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_flush  = w_ctrl.id_ex_flush;
  assign bus.redirect     = w_ctrl.redirect;
  assign bus.stall_cycles = w_stall_cnt;
  assign bus.flush_events = w_flush_cnt;
  assign bus.state_o      = rst_n ? r_state : ST_RUN;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LOAD_BUBBLES=1/3, CNT_W=4)
// share one stimulus stream; each step checks the instance it targets.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  localparam logic [7:0] E_FRZ  = 8'b0000_0000;
  localparam logic [7:0] E_RUN  = 8'b1111_1000;
  localparam logic [7:0] E_LU   = 8'b0011_1010;
  localparam logic [7:0] E_MP   = 8'b1111_1111;
  localparam logic [7:0] M_ALL  = 8'b1111_1111;
  localparam logic [7:0] M_LU   = 8'b1101_1111;

  pipe_hazard_ctrl_if #(.CNT_W(32)) b1 ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) b3 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  b4 ();

  pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(32)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  logic [7:0] c1, c3, c4;
  assign c1 = {b1.pc_en, b1.if_id_en, b1.id_ex_en, b1.ex_mem_en, b1.mem_wb_en,
               b1.if_id_flush, b1.id_ex_flush, b1.redirect};
  assign c3 = {b3.pc_en, b3.if_id_en, b3.id_ex_en, b3.ex_mem_en, b3.mem_wb_en,
               b3.if_id_flush, b3.id_ex_flush, b3.redirect};
  assign c4 = {b4.pc_en, b4.if_id_en, b4.id_ex_en, b4.ex_mem_en, b4.mem_wb_en,
               b4.if_id_flush, b4.id_ex_flush, b4.redirect};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] obs, input logic [7:0] exp,
                         input logic [7:0] mask);
    chk(tag, 64'(obs & mask), 64'(exp & mask));
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic wb,
                       input logic mtr, input logic mp, input logic busy);
    b1.rs1_id = rs1; b1.rs2_id = rs2; b1.rs1_used_id = u1; b1.rs2_used_id = u2;
    b1.rd_ex = rd; b1.wb_reg_file_ex = wb; b1.memtoreg_ex = mtr;
    b1.mispredict_ex = mp; b1.dmem_busy = busy;
    b3.rs1_id = rs1; b3.rs2_id = rs2; b3.rs1_used_id = u1; b3.rs2_used_id = u2;
    b3.rd_ex = rd; b3.wb_reg_file_ex = wb; b3.memtoreg_ex = mtr;
    b3.mispredict_ex = mp; b3.dmem_busy = busy;
    b4.rs1_id = rs1; b4.rs2_id = rs2; b4.rs1_used_id = u1; b4.rs2_used_id = u2;
    b4.rd_ex = rd; b4.wb_reg_file_ex = wb; b4.memtoreg_ex = mtr;
    b4.mispredict_ex = mp; b4.dmem_busy = busy;
    #1;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic drive_lu(input logic mp, input logic busy);
    drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, mp, busy);
  endtask

  task automatic drive_idle(input logic mp, input logic busy);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, mp, busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle(1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle(1'b0, 1'b0);
    tick();
    chk_ctl("rst_ctl", c1, E_FRZ, M_ALL);
    chk("rst_state", 64'(b1.state_o), 64'd0);
    chk("rst_stall", 64'(b1.stall_cycles), 64'd0);
    chk("rst_flush", 64'(b1.flush_events), 64'd0);
    rst_n = 1'b1;

    // Single-bubble load-use
    drive_lu(1'b0, 1'b0);
    chk_ctl("lu1_ctl", c1, E_LU, M_LU);
    tick();
    drive_idle(1'b0, 1'b0);
    chk_ctl("lu1_after", c1, E_RUN, M_ALL);
    chk("lu1_stall", 64'(b1.stall_cycles), 64'd1);
    chk("lu1_state", 64'(b1.state_o), 64'd0);

    // rd_ex = x0 never hazards, even when ID reads x0
    drive(5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("rd0_ctl", c1, E_RUN, M_ALL);
    // rs2 match but rs2 not read
    drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("rs2unused_ctl", c1, E_RUN, M_ALL);
    // non-load producer does not stall
    drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("noload_ctl", c1, E_RUN, M_ALL);
    // rs2-only hazard
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("rs2lu_ctl", c1, E_LU, M_LU);
    tick();
    drive_idle(1'b0, 1'b0);
    chk("rs2lu_stall", 64'(b1.stall_cycles), 64'd2);

    // LOAD_BUBBLES=3 with dmem_busy over the second bubble
    do_reset();
    drive_lu(1'b0, 1'b0);
    chk("lb3_c0_st", 64'(b3.state_o), 64'd0);
    chk_ctl("lb3_c0_ctl", c3, E_LU, M_LU);
    tick();
    drive_lu(1'b0, 1'b1);
    chk("lb3_c1_st", 64'(b3.state_o), 64'd1);
    chk_ctl("lb3_c1_ctl", c3, E_FRZ, M_ALL);
    tick();
    drive_lu(1'b0, 1'b1);
    chk("lb3_c2_st", 64'(b3.state_o), 64'd2);
    chk_ctl("lb3_c2_ctl", c3, E_FRZ, M_ALL);
    tick();
    drive_idle(1'b0, 1'b0);
    chk("lb3_c3_st", 64'(b3.state_o), 64'd2);
    chk_ctl("lb3_c3_ctl", c3, E_FRZ, M_ALL);
    tick();
    chk("lb3_c4_st", 64'(b3.state_o), 64'd1);
    chk_ctl("lb3_c4_ctl", c3, E_LU, M_LU);
    tick();
    chk("lb3_c5_st", 64'(b3.state_o), 64'd1);
    chk_ctl("lb3_c5_ctl", c3, E_LU, M_LU);
    tick();
    chk("lb3_c6_st", 64'(b3.state_o), 64'd0);
    chk_ctl("lb3_c6_ctl", c3, E_RUN, M_ALL);
    chk("lb3_stall", 64'(b3.stall_cycles), 64'd6);

    // Mispredict aborts a multi-bubble stall
    do_reset();
    drive_lu(1'b0, 1'b0);
    tick();
    drive_idle(1'b1, 1'b0);
    chk("abort_st", 64'(b3.state_o), 64'd1);
    chk_ctl("abort_ctl", c3, E_MP, M_ALL);
    tick();
    drive_idle(1'b0, 1'b0);
    chk("abort_st2", 64'(b3.state_o), 64'd0);
    chk("abort_flush", 64'(b3.flush_events), 64'd1);
    chk("abort_stall", 64'(b3.stall_cycles), 64'd1);

    // Mispredict overrides load-use
    do_reset();
    drive_lu(1'b1, 1'b0);
    chk_ctl("mplu_ctl", c1, E_MP, M_ALL);
    tick();
    drive_idle(1'b0, 1'b0);
    chk("mplu_flush", 64'(b1.flush_events), 64'd1);
    chk("mplu_stall", 64'(b1.stall_cycles), 64'd0);
    chk("mplu_state", 64'(b1.state_o), 64'd0);

    // Mispredict during a 4-cycle freeze
    do_reset();
    drive_idle(1'b0, 1'b1);
    chk_ctl("mw_c0_ctl", c1, E_FRZ, M_ALL);
    for (int i = 1; i < 4; i++) begin
      tick();
      drive_idle(1'b1, 1'b1);
      chk_ctl("mw_busy_ctl", c1, E_FRZ, M_ALL);
      chk("mw_busy_st", 64'(b1.state_o), 64'd2);
    end
    tick();
    drive_idle(1'b1, 1'b0);
    chk_ctl("mw_c4_ctl", c1, E_FRZ, M_ALL);
    chk("mw_c4_st", 64'(b1.state_o), 64'd2);
    tick();
    drive_idle(1'b0, 1'b0);
    chk("mw_c5_st", 64'(b1.state_o), 64'd3);
    chk_ctl("mw_c5_ctl", c1, E_MP, M_ALL);
    tick();
    chk("mw_c6_st", 64'(b1.state_o), 64'd0);
    chk_ctl("mw_c6_ctl", c1, E_RUN, M_ALL);
    chk("mw_flush", 64'(b1.flush_events), 64'd1);
    chk("mw_stall", 64'(b1.stall_cycles), 64'd5);

    // Reset while frozen with a pending redirect
    do_reset();
    drive_idle(1'b1, 1'b1);
    tick();
    drive_idle(1'b0, 1'b1);
    chk("rmw_st", 64'(b1.state_o), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctl("rmw_ctl", c1, E_FRZ, M_ALL);
    chk("rmw_st0", 64'(b1.state_o), 64'd0);
    chk("rmw_stall0", 64'(b1.stall_cycles), 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    drive_idle(1'b0, 1'b0);
    chk_ctl("rmw_rel_ctl", c1, E_RUN, M_ALL);
    tick();
    chk("rmw_rel_st", 64'(b1.state_o), 64'd0);
    chk_ctl("rmw_rel_ctl2", c1, E_RUN, M_ALL);
    chk("rmw_rel_flush", 64'(b1.flush_events), 64'd0);
    chk("rmw_rel_stall", 64'(b1.stall_cycles), 64'd0);

    // 4-bit stall counter saturates
    do_reset();
    drive_idle(1'b0, 1'b1);
    repeat (14) tick();
    chk("sat_14", 64'(b4.stall_cycles), 64'd14);
    repeat (6) tick();
    chk("sat_hold", 64'(b4.stall_cycles), 64'd15);
    chk("sat_flush", 64'(b4.flush_events), 64'd0);
    drive_idle(1'b0, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
